// File: rtl/mix_col_seq.sv
// AES MixColumns/InvMixColumns over COLS_PER_CYC columns per clock; result valid 4/COLS_PER_CYC cycles after accept.
// One state in flight: in_ready low from accept until the result handshake; DONE holds its result under back-pressure.
module mix_col_seq #(
  parameter int COLS_PER_CYC = 4,
  parameter bit INV_EN       = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cols
      $error("mix_col_seq: COLS_PER_CYC must be 1, 2 or 4");
    end
  endgenerate

  localparam int         N    = 4 / COLS_PER_CYC;
  localparam logic [1:0] LAST = 2'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state;
  logic [127:0] work;
  logic [1:0]   col_cnt;
  logic         inv_q;
  logic         inv_sel;
  logic [1:0]   col_idx;
  logic [127:0] mixed_work;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] fwd_row(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
    return xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
  endfunction

  // 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3 built from x2/x4/x8 multiples
  function automatic logic [7:0] inv_row(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] b0_2, b0_4, b0_8, b1_2, b1_8, b2_4, b2_8, b3_8;
    b0_2 = xt(a0);
    b0_4 = xt(b0_2);
    b0_8 = xt(b0_4);
    b1_2 = xt(a1);
    b1_8 = xt(xt(b1_2));
    b2_4 = xt(xt(a2));
    b2_8 = xt(b2_4);
    b3_8 = xt(xt(xt(a3)));
    return (b0_8 ^ b0_4 ^ b0_2) ^ (b1_8 ^ b1_2 ^ a1) ^ (b2_8 ^ b2_4 ^ a2) ^ (b3_8 ^ a3);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (inv)
      return {inv_row(a0, a1, a2, a3), inv_row(a1, a2, a3, a0),
              inv_row(a2, a3, a0, a1), inv_row(a3, a0, a1, a2)};
    else
      return {fwd_row(a0, a1, a2, a3), fwd_row(a1, a2, a3, a0),
              fwd_row(a2, a3, a0, a1), fwd_row(a3, a0, a1, a2)};
  endfunction

  // Tying the select low lets synthesis prune the inverse datapath entirely.
  assign inv_sel = INV_EN ? inv_q : 1'b0;

  always_comb begin
    mixed_work = work;
    col_idx    = 2'd0;
    for (int k = 0; k < COLS_PER_CYC; k++) begin
      col_idx = 2'(int'(col_cnt) * COLS_PER_CYC + k);
      mixed_work[32*col_idx +: 32] = mix_col(work[32*col_idx +: 32], inv_sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      col_cnt   <= 2'd0;
      inv_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            inv_q    <= INV_EN ? in_inv : 1'b0;
            col_cnt  <= 2'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          work <= mixed_work;
          if (col_cnt == LAST) begin
            col_cnt   <= 2'd0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            col_cnt <= col_cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = work;

endmodule

// File: tb/tb_mix_col_seq.sv
// Directed bench for mix_col_seq: four instances (1, 2, 4 columns/cycle with inverse, 4 columns/cycle forward-only).
module tb_mix_col_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [127:0] in_data   [4];
  logic         in_inv    [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [127:0] out_data  [4];
  logic         busy      [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mix_col_seq #(.COLS_PER_CYC(1), .INV_EN(1'b1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_inv(in_inv[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]));
  mix_col_seq #(.COLS_PER_CYC(2), .INV_EN(1'b1)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_inv(in_inv[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]));
  mix_col_seq #(.COLS_PER_CYC(4), .INV_EN(1'b1)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .in_inv(in_inv[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2]));
  mix_col_seq #(.COLS_PER_CYC(4), .INV_EN(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
    .in_inv(in_inv[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
    .busy(busy[3]));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full transaction on instance i; in_inv is flipped right after accept to show it is sampled once.
  task automatic xfer(input int i, input logic [127:0] d, input logic inv,
                      output logic [127:0] res, output int lat);
    int   guard;
    logic ready_low;
    @(negedge clk);
    in_data[i]  = d;
    in_inv[i]   = inv;
    in_valid[i] = 1'b1;
    guard = 0;
    while (!in_ready[i] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready[i]) check("accept_timeout", 128'(in_ready[i]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_inv[i]   = ~inv;
    lat       = 0;
    ready_low = 1'b1;
    while (!out_valid[i] && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (in_ready[i]) ready_low = 1'b0;
    end
    if (!out_valid[i]) check("result_timeout", 128'(out_valid[i]), 128'd1);
    res = out_data[i];
    check("ready_low_in_flight", 128'(ready_low), 128'd1);
    out_ready[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[i] = 1'b0;
    check("idle_after_handshake", {126'd0, out_valid[i], in_ready[i]}, 128'd1);
  endtask

  localparam logic [127:0] FIPS_IN   = {4{32'hdb135345}};
  localparam logic [127:0] FIPS_OUT  = {4{32'h8e4da1bc}};
  localparam logic [127:0] MIXED_IN  = {32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'h01010101};
  localparam logic [127:0] MIXED_OUT = {32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'h01010101};
  localparam logic [127:0] FIXED_PT  = {32'h01010101, 32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6};

  initial begin
    logic [127:0] res, mid, d, held;
    int           lat;
    int           exp_lat [3];
    logic         seen;

    exp_lat[0] = 4;
    exp_lat[1] = 2;
    exp_lat[2] = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_inv[i]    = 1'b0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      check("reset_outputs", {124'd0, in_ready[i], out_valid[i], busy[i], 1'b0}, 128'h8);
      check("reset_out_data", out_data[i], '0);
    end

    // Forward FIPS-197 vector and per-configuration latency
    for (int i = 0; i < 3; i++) begin
      xfer(i, FIPS_IN, 1'b0, res, lat);
      check("fwd_fips", res, FIPS_OUT);
      check("latency", 128'(lat), 128'(exp_lat[i]));
      xfer(i, MIXED_IN, 1'b0, res, lat);
      check("fwd_mixed_cols", res, MIXED_OUT);
    end

    for (int i = 0; i < 3; i++) begin
      xfer(i, FIPS_OUT, 1'b1, res, lat);
      check("inv_fips", res, FIPS_IN);
      xfer(i, FIXED_PT, 1'b1, res, lat);
      check("inv_fixed_points", res, FIXED_PT);
    end
    xfer(2, FIXED_PT, 1'b0, res, lat);
    check("fwd_fixed_points", res, FIXED_PT);

    xfer(3, FIPS_IN, 1'b1, res, lat);
    check("fwd_only_ignores_inv", res, FIPS_OUT);

    for (int k = 0; k < 100; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      xfer(k % 3, d, 1'b0, mid, lat);
      xfer(k % 3, mid, 1'b1, res, lat);
      check("round_trip", res, d);
    end

    // Back-pressure: result held in DONE while a second state waits on in_valid
    @(negedge clk);
    in_data[0]  = FIPS_IN;
    in_inv[0]   = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data[0] = MIXED_IN;
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_reach_done", 128'(out_valid[0]), 128'd1);
    held = out_data[0];
    check("bp_result", held, FIPS_OUT);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_data", out_data[0], held);
      check("bp_hold_flags", {125'd0, out_valid[0], in_ready[0], busy[0]}, 128'h5);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_release_idle", {125'd0, out_valid[0], in_ready[0], busy[0]}, 128'h2);
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("bp_next_accepted", {126'd0, in_ready[0], busy[0]}, 128'h1);
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_second_result", out_data[0], MIXED_OUT);
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;

    // Reset two cycles into a 4-cycle operation
    @(negedge clk);
    in_data[0]  = FIPS_IN;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_flags", {125'd0, out_valid[0], in_ready[0], busy[0]}, 128'h2);
    check("rst_mid_data", out_data[0], '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check("rst_no_out_pulse", 128'(seen), 128'd0);
    check("rst_stays_idle", 128'(in_ready[0]), 128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
